uart_word_assembler: RTL and testbench

UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

---
 rtl/uart_word_assembler.sv | 144 ++++++++++++++
 tb/tb_uart_word_assembler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_assembler.sv
// uart_word_assembler
//
// Collects bytes from a UART receiver into 32-bit words, little-endian
// (first byte lands in bits [7:0]). A completed word moves into a registered
// output slot that is held until downstream accepts it. While that slot is
// occupied, the next word keeps assembling in the partial register, so there
// is one word of double buffering.
//
// Handshake: word_valid=1 means word_out holds an unconsumed word. A transfer
// happens on a rising clk edge where word_valid=1 and word_ready=1. word_out
// and word_valid stay stable until that transfer. word_valid drops on the
// transfer edge unless a new word loads on the same edge.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low
//   rx_byte      byte from the UART receiver, qualified by rx_valid
//   rx_valid     one-cycle strobe for rx_byte / rx_err
//   rx_err       framing/parity error for the strobed byte
//   word_out     assembled word (registered)
//   word_valid   word_out holds an unconsumed word
//   word_ready   downstream accepts word_out
//   err_clear    clears the sticky error flags
//   error_flag   bit0 = overrun, bit1 = framing/timeout (both sticky)
//   byte_count   bytes currently held in the partial word
//   fsm_state    current state (0 = IDLE, 1 = COLLECT), for debug/checkers
//
// TIMEOUT_CYCLES: consecutive idle cycles in COLLECT after which a partial
// word is discarded (2..65535).

module uart_word_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  input  logic        err_clear,
  output logic [1:0]  error_flag,
  output logic [1:0]  byte_count,
  output logic        fsm_state
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [23:0] partial;
  logic [15:0] idle_cnt;

  logic good_byte;
  logic bad_byte;
  logic word_done;
  logic can_load;
  logic timeout_hit;
  logic handshake;

  assign good_byte   = rx_valid && !rx_err;
  assign bad_byte    = rx_valid && rx_err;
  assign word_done   = good_byte && (byte_count == 2'd3);
  // The slot is free if empty or being emptied on this very edge.
  assign can_load    = !word_valid || word_ready;
  // idle_cnt holds the number of idle cycles already seen, so the edge that
  // ends the TIMEOUT_CYCLES-th idle cycle is when it equals TIMEOUT_CYCLES-1.
  assign timeout_hit = (state == COLLECT) && !rx_valid && (idle_cnt == TIMEOUT_LAST);
  assign handshake   = word_valid && word_ready;
  assign fsm_state   = (state == COLLECT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      partial    <= 24'h0;
      idle_cnt   <= 16'h0;
      byte_count <= 2'd0;
      word_out   <= 32'h0;
      word_valid <= 1'b0;
      error_flag <= 2'b00;
    end else begin
      // Sticky flags: a new error event on the same edge as err_clear wins.
      error_flag[0] <= (error_flag[0] && !err_clear) || (word_done && !can_load);
      error_flag[1] <= (error_flag[1] && !err_clear) || bad_byte || timeout_hit;

      // Output slot. A word completing into an occupied, non-accepting slot
      // is dropped (overrun flagged above).
      if (word_done && can_load) begin
        word_out   <= {rx_byte, partial};
        word_valid <= 1'b1;
      end else if (handshake) begin
        word_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          idle_cnt <= 16'h0;
          if (good_byte) begin
            partial    <= {16'h0, rx_byte};
            byte_count <= 2'd1;
            state      <= COLLECT;
          end
        end

        COLLECT: begin
          if (rx_valid) begin
            idle_cnt <= 16'h0;
            if (rx_err || byte_count == 2'd3) begin
              // Error discards the partial word; a 4th good byte has just
              // been handed to the output slot (or dropped as overrun).
              partial    <= 24'h0;
              byte_count <= 2'd0;
              state      <= IDLE;
            end else begin
              case (byte_count)
                2'd1:    partial[15:8]  <= rx_byte;
                2'd2:    partial[23:16] <= rx_byte;
                default: partial[7:0]   <= rx_byte;
              endcase
              byte_count <= byte_count + 2'd1;
            end
          end else if (timeout_hit) begin
            idle_cnt   <= 16'h0;
            partial    <= 24'h0;
            byte_count <= 2'd0;
            state      <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Testbench for uart_word_assembler.
// Inputs change 3 time units after each rising edge; DUT outputs are sampled
// on the falling edge and compared against a byte-queue reference model.

module tb_uart_word_assembler;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_err = 1'b0;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        err_clear = 1'b0;
  logic [1:0]  error_flag;
  logic [1:0]  byte_count;
  logic        fsm_state;

  always #5 clk = ~clk;

  uart_word_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .err_clear  (err_clear),
    .error_flag (error_flag),
    .byte_count (byte_count),
    .fsm_state  (fsm_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Partial word is a queue of received bytes; the word is formed by
  // weighting byte i with 256**i when the 4th byte arrives.
  logic [7:0]  m_part[$];
  int          m_idle = 0;
  logic [31:0] m_word = 32'h0;
  logic        m_valid = 1'b0;
  logic [1:0]  m_err = 2'b00;
  logic [31:0] exp_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_part.delete();
      m_idle  = 0;
      m_word  = 32'h0;
      m_valid = 1'b0;
      m_err   = 2'b00;
      exp_q.delete();
    end else begin
      logic        hs, loaded, ev_over, ev_frame;
      logic [31:0] w;
      hs = m_valid && word_ready;
      loaded = 1'b0;
      ev_over = 1'b0;
      ev_frame = 1'b0;
      w = 32'h0;
      if (rx_valid) begin
        m_idle = 0;
        if (rx_err) begin
          m_part.delete();
          ev_frame = 1'b1;
        end else begin
          m_part.push_back(rx_byte);
          if (m_part.size() == 4) begin
            for (int i = 0; i < 4; i++) w = w + (32'(m_part[i]) << (8 * i));
            m_part.delete();
            if (!m_valid || word_ready) begin
              m_word = w;
              loaded = 1'b1;
              exp_q.push_back(w);
            end else begin
              ev_over = 1'b1;
            end
          end
        end
      end else if (m_part.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_part.delete();
          m_idle = 0;
          ev_frame = 1'b1;
        end
      end else begin
        m_idle = 0;
      end
      if (loaded) m_valid = 1'b1;
      else if (hs) m_valid = 1'b0;
      if (err_clear) m_err = 2'b00;
      m_err = m_err | {ev_frame, ev_over};
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    check("cyc_word_valid", 32'(word_valid), 32'(m_valid));
    check("cyc_word_out", word_out, m_word);
    check("cyc_error_flag", 32'(error_flag), 32'(m_err));
    check("cyc_byte_count", 32'(byte_count), 32'(m_part.size()));
    check("cyc_fsm_state", 32'(fsm_state), 32'(m_part.size() != 0));
    if (reset && word_valid && word_ready) begin
      if (exp_q.size() == 0) check("sb_word_expected", 32'd0, 32'd1);
      else check("sb_handshake_word", word_out, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 3 time units after a rising edge.
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_byte  = b;
    rx_err   = err;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 reset = 1'b0;
    idle(3);
    check("reset_word_out", word_out, 32'h0);
    check("reset_word_valid", 32'(word_valid), 32'd0);
    check("reset_error_flag", 32'(error_flag), 32'd0);
    check("reset_byte_count", 32'(byte_count), 32'd0);
    reset = 1'b1;
    idle(2);

    // Basic word with downstream ready.
    word_ready = 1'b1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("basic_count2", 32'(byte_count), 32'd2);
    send_byte(8'h33, 1'b0);
    check("basic_no_early_valid", 32'(word_valid), 32'd0);
    send_byte(8'h44, 1'b0);
    check("basic_word", word_out, 32'h44332211);
    check("basic_valid", 32'(word_valid), 32'd1);
    check("basic_err", 32'(error_flag), 32'd0);
    idle(1);
    check("basic_valid_one_cycle", 32'(word_valid), 32'd0);
    word_ready = 1'b0;
    idle(2);

    // Overrun: second word dropped while the first is unconsumed.
    send_word(32'hDDCCBBAA);
    check("ovr_first", word_out, 32'hDDCCBBAA);
    send_word(32'h04030201);
    check("ovr_word_kept", word_out, 32'hDDCCBBAA);
    check("ovr_still_valid", 32'(word_valid), 32'd1);
    check("ovr_flag", 32'(error_flag), 32'b01);
    check("ovr_count", 32'(byte_count), 32'd0);
    word_ready = 1'b1;
    idle(1);
    word_ready = 1'b0;
    check("ovr_drained", 32'(word_valid), 32'd0);
    clear_errors();
    check("ovr_cleared", 32'(error_flag), 32'd0);

    // Word completing on the same edge as a handshake.
    send_word(32'h87654321);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0);
    word_ready = 1'b1;
    send_byte(8'hDE, 1'b0);
    word_ready = 1'b0;
    check("hs_load_valid", 32'(word_valid), 32'd1);
    check("hs_load_word", word_out, 32'hDEADBEEF);
    check("hs_load_no_ovr", 32'(error_flag), 32'd0);
    word_ready = 1'b1;
    idle(1);
    word_ready = 1'b0;
    check("hs_load_drained", 32'(word_valid), 32'd0);

    // Framing error mid-word.
    word_ready = 1'b1;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'h00, 1'b1);
    check("ferr_count", 32'(byte_count), 32'd0);
    check("ferr_flag", 32'(error_flag), 32'b10);
    send_word(32'h04030201);
    check("ferr_word", word_out, 32'h04030201);
    idle(1);
    clear_errors();

    // Timeout.
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    idle(TO - 1);
    check("to_not_yet", 32'(byte_count), 32'd2);
    idle(1);
    check("to_count", 32'(byte_count), 32'd0);
    check("to_flag", 32'(error_flag), 32'b10);
    send_word(32'h04030201);
    check("to_word", word_out, 32'h04030201);
    idle(1);
    clear_errors();

    // Reset mid-word.
    word_ready = 1'b0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'hA6, 1'b0);
    reset = 1'b0;
    idle(2);
    check("rst_count", 32'(byte_count), 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    reset = 1'b1;
    idle(1);
    send_byte(8'hA1, 1'b0);
    check("rst_no_valid1", 32'(word_valid), 32'd0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    check("rst_no_valid3", 32'(word_valid), 32'd0);
    send_byte(8'hA4, 1'b0);
    check("rst_word", word_out, 32'hA4A3A2A1);
    word_ready = 1'b1;
    idle(1);
    word_ready = 1'b0;

    // err_clear racing an error event, then alone.
    err_clear = 1'b1;
    send_byte(8'h00, 1'b1);
    err_clear = 1'b0;
    check("clr_race_flag", 32'(error_flag[1]), 32'd1);
    idle(2);
    clear_errors();
    check("clr_alone", 32'(error_flag), 32'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rx_valid  = 1'b0;
        err_clear = 1'b0;
        word_ready = ($urandom_range(0, 1) == 1);
        idle($urandom_range(TO - 4, TO + 4));
      end else begin
        rx_byte    = 8'($urandom_range(0, 255));
        rx_valid   = ($urandom_range(0, 99) < 50);
        rx_err     = ($urandom_range(0, 99) < 6);
        word_ready = ($urandom_range(0, 99) < 40);
        err_clear  = ($urandom_range(0, 99) < 5);
        step();
      end
      if (i == 300) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
    end
    rx_valid = 1'b0;
    err_clear = 1'b0;
    word_ready = 1'b1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
